// File: rtl/fifo_replay_ctrl.sv
// Replay sequencer for a single Fifo: loads N words once, then streams them E times,
// rewinding the Fifo read head between passes.
module fifo_replay_ctrl #(
    parameter int addrLen  = 5,
    parameter int epochLen = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [addrLen-1:0]  numEntries,
    input  logic [epochLen-1:0] numEpochs,
    input  logic                srcValid,
    output logic                srcReady,
    output logic                dstValid,
    input  logic                dstReady,
    output logic                fifoRd,
    output logic                fifoWrt,
    output logic                fifoRestart,
    output logic                fifoClear,
    input  logic                fifoEmpty,
    input  logic                fifoFull,
    output logic                epochDone,
    output logic                done,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, LOAD, REPLAY, REWIND, FINISH} stateT;

    stateT               state;
    logic [addrLen-1:0]  loadCnt;
    logic [addrLen-1:0]  rdCnt;
    logic [epochLen-1:0] epochCnt;
    logic [addrLen-1:0]  nReg;
    logic [epochLen-1:0] eReg;

    logic lastLoad;
    logic lastRead;
    logic lastEpoch;

    // Handshakes are combinational so a word moves in the same cycle it is offered.
    assign srcReady  = (state == LOAD) && (loadCnt < nReg) && !fifoFull;
    assign fifoWrt   = srcValid && srcReady;
    assign dstValid  = (state == REPLAY) && !fifoEmpty && (rdCnt < nReg);
    assign fifoRd    = dstValid && dstReady;

    assign lastLoad  = fifoWrt && (loadCnt == nReg - 1'b1);
    assign lastRead  = fifoRd && (rdCnt == nReg - 1'b1);
    assign lastEpoch = (epochCnt == eReg - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            loadCnt     <= '0;
            rdCnt       <= '0;
            epochCnt    <= '0;
            nReg        <= '0;
            eReg        <= '0;
            fifoRestart <= 1'b0;
            fifoClear   <= 1'b0;
            epochDone   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fifoRestart <= 1'b0;
            fifoClear   <= 1'b0;
            epochDone   <= 1'b0;
            done        <= 1'b0;
            if (fifoWrt) loadCnt <= loadCnt + 1'b1;
            if (fifoRd) rdCnt <= rdCnt + 1'b1;
            if (lastRead) epochCnt <= epochCnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        nReg     <= numEntries;
                        eReg     <= numEpochs;
                        loadCnt  <= '0;
                        rdCnt    <= '0;
                        epochCnt <= '0;
                        busy     <= 1'b1;
                        if (numEntries != '0 && numEpochs != '0) begin
                            state <= LOAD;
                        end else begin
                            // Empty job: report completion without touching the Fifo.
                            state     <= FINISH;
                            fifoClear <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= FINISH;
                        fifoClear <= 1'b1;
                    end else if (lastLoad) begin
                        state <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (abort) begin
                        state     <= FINISH;
                        fifoClear <= 1'b1;
                    end else if (lastRead) begin
                        epochDone <= 1'b1;
                        if (lastEpoch) begin
                            state     <= FINISH;
                            fifoClear <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state       <= REWIND;
                            fifoRestart <= 1'b1;
                        end
                    end
                end
                REWIND: begin
                    rdCnt <= '0;
                    if (abort) begin
                        state     <= FINISH;
                        fifoClear <= 1'b1;
                    end else begin
                        state <= REPLAY;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_replay_ctrl.sv
// Directed bench for fifo_replay_ctrl with a small behavioural Fifo whose write data is
// base + tail, so every read value identifies the slot it came from.
module tb_fifo_replay_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] numEntries = '0;
    logic [7:0] numEpochs = '0;
    logic       srcValid = 1'b0;
    logic       dstReady = 1'b0;
    logic       srcReady, dstValid, fifoRd, fifoWrt, fifoRestart, fifoClear;
    logic       fifoEmpty, fifoFull, epochDone, done, busy;

    fifo_replay_ctrl #(.addrLen(5), .epochLen(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .numEntries(numEntries), .numEpochs(numEpochs),
        .srcValid(srcValid), .srcReady(srcReady), .dstValid(dstValid), .dstReady(dstReady),
        .fifoRd(fifoRd), .fifoWrt(fifoWrt), .fifoRestart(fifoRestart), .fifoClear(fifoClear),
        .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
        .epochDone(epochDone), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 32-deep Fifo: first-word-fall-through read, restart rewinds head only.
    logic [7:0] mem [0:31];
    logic [4:0] head, tail;
    logic       fullFlag;
    logic [7:0] srcBase = 8'h00;
    logic [7:0] dataIn, dataOut;

    assign dataIn    = srcBase + {3'b000, tail};
    assign dataOut   = mem[head];
    assign fifoEmpty = (head == tail) && !fullFlag;
    assign fifoFull  = fullFlag;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0; tail <= '0; fullFlag <= 1'b0;
        end else if (fifoClear) begin
            head <= '0; tail <= '0; fullFlag <= 1'b0;
        end else begin
            if (fifoRestart) head <= '0;
            else if (fifoRd) head <= head + 5'd1;
            if (fifoWrt) begin
                mem[tail] <= dataIn;
                tail <= tail + 5'd1;
            end
            if (fifoRd) fullFlag <= 1'b0;
            else if (fifoWrt && (5'(tail + 5'd1) == head)) fullFlag <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wrN = 0, rdN = 0, epN = 0, doneN = 0, clrN = 0, rstN = 0;
    int bothN = 0, fullN = 0, noReadyN = 0;
    int lastWrCyc = 0, lastRdCyc = 0, doneCyc = 0;
    logic [7:0] rdData [0:511];
    int         rdCyc  [0:511];

    always @(negedge clk) begin
        if (!reset) begin
            if (fifoWrt) begin wrN <= wrN + 1; lastWrCyc <= cyc; end
            if (fifoRd && rdN < 512) begin
                rdData[rdN] <= dataOut; rdCyc[rdN] <= cyc; rdN <= rdN + 1; lastRdCyc <= cyc;
            end
            if (epochDone)   epN <= epN + 1;
            if (done) begin doneN <= doneN + 1; doneCyc <= cyc; end
            if (fifoClear)   clrN <= clrN + 1;
            if (fifoRestart) rstN <= rstN + 1;
            if (fifoRd && fifoWrt) bothN <= bothN + 1;
            if (fifoFull)    fullN <= fullN + 1;
            if (fifoRd && !dstReady) noReadyN <= noReadyN + 1;
        end
    end

    int nCmp = 0;
    int nFail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [4:0] n, input logic [7:0] e);
        numEntries = n;
        numEpochs  = e;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit randSrc, input bit toggleReady, output bit ok);
        int d0;
        d0 = doneN;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (randSrc) srcValid = 1'($urandom_range(0, 1));
            if (toggleReady) dstReady = ~dstReady;
            tick();
            if (doneN != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        #1 reset = 1'b1;
        #2;
        outs = {srcReady, dstValid, fifoRd, fifoWrt, fifoRestart, fifoClear, epochDone, done, busy};
        nCmp++;
        if (outs !== 9'b0) begin
            nFail++; $display("FAIL reset_outputs got=%b want=%b", outs, 9'b0);
        end
        @(negedge clk) reset = 1'b0;
        tick();
        nCmp++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        int w0, r0, e0, d0, c0, s0, b0, bad;
        bit ok;
        w0 = wrN; r0 = rdN; e0 = epN; d0 = doneN; c0 = clrN; s0 = rstN; b0 = bothN;
        srcBase = 8'h0A; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(5'd4, 8'd3);
        waitDone(100, 1'b0, 1'b0, ok);
        srcValid = 1'b0;
        nCmp++; if (!ok) begin nFail++; $display("FAIL basic_timeout got=none want=done"); end
        nCmp++; if (wrN - w0 != 4) begin nFail++; $display("FAIL basic_writes got=%0d want=4", wrN - w0); end
        nCmp++; if (rdN - r0 != 12) begin nFail++; $display("FAIL basic_reads got=%0d want=12", rdN - r0); end
        bad = 0;
        for (int i = 0; i < 12; i++) if (rdData[r0 + i] !== 8'h0A + 8'(i % 4)) bad++;
        nCmp++; if (bad != 0) begin nFail++; $display("FAIL basic_data got=%0d bad words want=0", bad); end
        nCmp++; if (epN - e0 != 3) begin nFail++; $display("FAIL basic_epochDone got=%0d want=3", epN - e0); end
        nCmp++; if (doneN - d0 != 1) begin nFail++; $display("FAIL basic_done got=%0d want=1", doneN - d0); end
        nCmp++; if (clrN - c0 != 1) begin nFail++; $display("FAIL basic_clear got=%0d want=1", clrN - c0); end
        nCmp++; if (rstN - s0 != 2) begin nFail++; $display("FAIL basic_restart got=%0d want=2", rstN - s0); end
        nCmp++; if (bothN != b0) begin nFail++; $display("FAIL basic_rd_and_wrt got=%0d want=0", bothN - b0); end
        // Done is 14 edges after the edge committing the last write, i.e. 15 cycles later.
        nCmp++; if (doneCyc - lastWrCyc != 15) begin nFail++; $display("FAIL basic_done_latency got=%0d want=15", doneCyc - lastWrCyc); end
        nCmp++; if (rdCyc[r0 + 4] - rdCyc[r0 + 3] != 2) begin nFail++; $display("FAIL basic_bubble got=%0d want=2", rdCyc[r0 + 4] - rdCyc[r0 + 3]); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_max_entries();
        int w0, r0, e0, f0, bad;
        bit ok;
        w0 = wrN; r0 = rdN; e0 = epN; f0 = fullN;
        srcBase = 8'h20; srcValid = 1'b0; dstReady = 1'b1;
        pulseStart(5'd31, 8'd1);
        waitDone(400, 1'b1, 1'b0, ok);
        srcValid = 1'b0;
        nCmp++; if (!ok) begin nFail++; $display("FAIL max_timeout got=none want=done"); end
        nCmp++; if (wrN - w0 != 31) begin nFail++; $display("FAIL max_writes got=%0d want=31", wrN - w0); end
        nCmp++; if (fullN != f0) begin nFail++; $display("FAIL max_full got=%0d cycles want=0", fullN - f0); end
        nCmp++; if (rdN - r0 != 31) begin nFail++; $display("FAIL max_reads got=%0d want=31", rdN - r0); end
        bad = 0;
        for (int i = 0; i < 31; i++) if (rdData[r0 + i] !== 8'h20 + 8'(i)) bad++;
        nCmp++; if (bad != 0) begin nFail++; $display("FAIL max_data got=%0d bad words want=0", bad); end
        nCmp++; if (doneCyc != lastRdCyc + 1) begin nFail++; $display("FAIL max_done_after_read got=%0d want=%0d", doneCyc, lastRdCyc + 1); end
        nCmp++; if (epN - e0 != 1) begin nFail++; $display("FAIL max_epochDone got=%0d want=1", epN - e0); end
    endtask

    task automatic test_zero_start(input logic [4:0] n, input logic [7:0] e);
        int w0, r0, e0;
        w0 = wrN; r0 = rdN; e0 = epN;
        srcBase = 8'hE0; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(n, e);
        nCmp++; if (done !== 1'b1) begin nFail++; $display("FAIL zero_done n=%0d e=%0d got=%b want=1", n, e, done); end
        nCmp++; if (epochDone !== 1'b0) begin nFail++; $display("FAIL zero_epochDone n=%0d e=%0d got=%b want=0", n, e, epochDone); end
        nCmp++; if (fifoClear !== 1'b1) begin nFail++; $display("FAIL zero_clear n=%0d e=%0d got=%b want=1", n, e, fifoClear); end
        tick();
        srcValid = 1'b0;
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL zero_busy n=%0d e=%0d got=%b want=0", n, e, busy); end
        nCmp++; if (wrN != w0 || rdN != r0 || epN != e0) begin
            nFail++; $display("FAIL zero_no_ops got=wr%0d/rd%0d/ep%0d want=0/0/0", wrN - w0, rdN - r0, epN - e0);
        end
    endtask

    task automatic test_ready_toggle();
        int r0, e0, n0, bad;
        bit ok;
        r0 = rdN; e0 = epN; n0 = noReadyN;
        srcBase = 8'h40; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(5'd5, 8'd2);
        waitDone(200, 1'b0, 1'b1, ok);
        srcValid = 1'b0; dstReady = 1'b1;
        nCmp++; if (!ok) begin nFail++; $display("FAIL toggle_timeout got=none want=done"); end
        nCmp++; if (rdN - r0 != 10) begin nFail++; $display("FAIL toggle_reads got=%0d want=10", rdN - r0); end
        bad = 0;
        for (int i = 0; i < 10; i++) if (rdData[r0 + i] !== 8'h40 + 8'(i % 5)) bad++;
        nCmp++; if (bad != 0) begin nFail++; $display("FAIL toggle_data got=%0d bad words want=0", bad); end
        nCmp++; if (noReadyN != n0) begin nFail++; $display("FAIL toggle_rd_without_ready got=%0d want=0", noReadyN - n0); end
        nCmp++; if (epN - e0 != 2) begin nFail++; $display("FAIL toggle_epochDone got=%0d want=2", epN - e0); end
    endtask

    task automatic test_abort();
        int r0, e0, d0, r1, bad;
        bit ok;
        r0 = rdN; e0 = epN; d0 = doneN;
        srcBase = 8'h60; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(5'd4, 8'd3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rdN - r0 == 6) begin ok = 1'b1; break; end
        end
        nCmp++; if (!ok) begin nFail++; $display("FAIL abort_reach got=%0d reads want=6", rdN - r0); end
        abort = 1'b1; dstReady = 1'b0; srcValid = 1'b0;
        tick();
        abort = 1'b0;
        nCmp++; if (fifoClear !== 1'b1) begin nFail++; $display("FAIL abort_clear got=%b want=1", fifoClear); end
        nCmp++; if (done !== 1'b0 || epochDone !== 1'b0) begin
            nFail++; $display("FAIL abort_no_done got=done%b/ep%b want=0/0", done, epochDone);
        end
        tick();
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL abort_busy got=%b want=0", busy); end
        nCmp++; if (rdN - r0 != 6 || epN - e0 != 1 || doneN != d0) begin
            nFail++; $display("FAIL abort_counts got=rd%0d/ep%0d/done%0d want=6/1/0", rdN - r0, epN - e0, doneN - d0);
        end
        r1 = rdN;
        srcBase = 8'h80; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(5'd3, 8'd1);
        waitDone(50, 1'b0, 1'b0, ok);
        srcValid = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) if (rdData[r1 + i] !== 8'h80 + 8'(i)) bad++;
        nCmp++; if (!ok || rdN - r1 != 3 || bad != 0) begin
            nFail++; $display("FAIL abort_fresh_job got=ok%0d/rd%0d/bad%0d want=1/3/0", ok, rdN - r1, bad);
        end
    endtask

    task automatic test_async_reset();
        int w0, r1, e1, bad;
        bit ok;
        logic [8:0] outs;
        w0 = wrN;
        srcBase = 8'h90; srcValid = 1'b1; dstReady = 1'b1;
        pulseStart(5'd6, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wrN - w0 == 3) begin ok = 1'b1; break; end
            tick();
        end
        nCmp++; if (!ok) begin nFail++; $display("FAIL areset_reach got=%0d writes want=3", wrN - w0); end
        #2 reset = 1'b1;
        #1;
        outs = {srcReady, dstValid, fifoRd, fifoWrt, fifoRestart, fifoClear, epochDone, done, busy};
        nCmp++; if (outs !== 9'b0) begin nFail++; $display("FAIL areset_outputs got=%b want=%b", outs, 9'b0); end
        #2 reset = 1'b0;
        srcValid = 1'b0;
        tick();
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL areset_idle got=%b want=0", busy); end
        r1 = rdN; e1 = epN;
        srcBase = 8'hB0; srcValid = 1'b1;
        pulseStart(5'd2, 8'd2);
        waitDone(50, 1'b0, 1'b0, ok);
        srcValid = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) if (rdData[r1 + i] !== 8'hB0 + 8'(i % 2)) bad++;
        nCmp++; if (!ok || rdN - r1 != 4 || bad != 0 || epN - e1 != 2) begin
            nFail++; $display("FAIL areset_fresh_job got=ok%0d/rd%0d/bad%0d/ep%0d want=1/4/0/2", ok, rdN - r1, bad, epN - e1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_entries();
        test_zero_start(5'd0, 8'd3);
        test_zero_start(5'd4, 8'd0);
        test_ready_toggle();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
